// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package display_pkg;

    // A digit is either lit (SHOW) or in the all-anodes-off guard band (GAP).
    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    // Larger of two phase lengths; the shared counter must cover both.
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of the phase counter; never less than one bit.
    function automatic int count_width(input int prescale, input int guard);
        int longest;
        longest = max_of(prescale, guard);
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

    // Electrical level of one anode line given whether its digit is selected.
    // Applied bit by bit across the one-hot digit select to form the anode bus.
    function automatic logic anode_level(input logic selected, input logic active_low);
        return selected ^ active_low;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Loadable down-counter timing one scan phase; done is high while the count is zero.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Reload at the start of each phase, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Outputs are registered from the next scan position, so every output change
// lines up with the clock edge on which the scan position changes.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int PRESCALE      = 50000,
    parameter int GUARD         = 500,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [4*DIGITS-1:0]   i_VALUE,
    input  logic                  i_LOAD,
    input  logic [DIGITS-1:0]     i_DP,
    input  logic                  i_LZB,
    output logic [3:0]            o_HALFBYTE,
    output logic [DIGITS-1:0]     o_AN,
    output logic                  o_DP,
    output logic                  o_BLANK
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int VAL_W = 4 * DIGITS;
    localparam int CNT_W = count_width(PRESCALE, GUARD);
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};

    scan_state_t        state, next_state;
    logic [IDX_W-1:0]   index, next_index;
    logic [VAL_W-1:0]   shadow_value, active_value, next_value;
    logic [DIGITS-1:0]  shadow_dp, active_dp, next_dp;
    logic               lead_in, show_done, gap_done, frame_start;
    logic               timer_done, timer_load;
    logic [CNT_W-1:0]   timer_value;
    logic [DIGITS-1:0]  upper_zero;
    logic [DIGITS-1:0]  next_an;
    logic [3:0]         next_nibble;
    logic               next_dp_bit, next_blank;

    // Phase timer shared by the SHOW and GAP phases.
    scan_prescaler #(
        .WIDTH(CNT_W)
    ) u_prescaler (
        .clk       (i_CLK),
        .rst       (i_RST),
        .load      (timer_load),
        .load_value(timer_value),
        .done      (timer_done)
    );

    // Next scan position and frame-boundary value swap. The first edge after
    // reset (SHOW with anodes still dark) starts digit 0 and counts as a frame start.
    always_comb begin
        lead_in     = (state == SHOW) && (o_AN == AN_OFF);
        show_done   = (state == SHOW) && !lead_in && timer_done;
        gap_done    = (state == GAP) && timer_done;
        frame_start = lead_in || (gap_done && (index == IDX_W'(DIGITS - 1)));
        next_state  = state;
        next_index  = index;
        timer_load  = 1'b0;
        timer_value = CNT_W'(PRESCALE - 1);
        if (lead_in) begin
            timer_load = 1'b1;
        end else if (show_done) begin
            next_state  = GAP;
            timer_load  = 1'b1;
            timer_value = CNT_W'(GUARD - 1);
        end else if (gap_done) begin
            next_state = SHOW;
            timer_load = 1'b1;
            next_index = frame_start ? '0 : index + 1'b1;
        end
        next_value = active_value;
        next_dp    = active_dp;
        if (frame_start) begin
            next_value = i_LOAD ? i_VALUE : shadow_value;
            next_dp    = i_LOAD ? i_DP : shadow_dp;
        end
    end

    // Per-digit view of the value about to be displayed, including leading-zero blanking.
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            upper_zero[k] = 1'b1;
            for (int j = k; j < DIGITS; j++) begin
                if (next_value[4*j +: 4] != 4'h0) begin
                    upper_zero[k] = 1'b0;
                end
            end
        end
        next_nibble = 4'h0;
        next_dp_bit = 1'b0;
        next_blank  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            next_an[k] = anode_level(next_index == IDX_W'(k), AN_ACTIVE_LOW);
            if (next_index == IDX_W'(k)) begin
                next_nibble = next_value[4*k +: 4];
                next_dp_bit = next_dp[k];
                next_blank  = i_LZB && (k != 0) && upper_zero[k];
            end
        end
    end

    // Scan state plus shadow/active value registers; the last load before a frame start wins.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state        <= SHOW;
            index        <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            active_value <= '0;
            active_dp    <= '0;
        end else begin
            state        <= next_state;
            index        <= next_index;
            active_value <= next_value;
            active_dp    <= next_dp;
            if (i_LOAD) begin
                shadow_value <= i_VALUE;
                shadow_dp    <= i_DP;
            end
        end
    end

    // Registered display outputs; the nibble holds through the guard band.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_AN       <= AN_OFF;
            o_HALFBYTE <= 4'h0;
            o_DP       <= 1'b0;
            o_BLANK    <= 1'b1;
        end else if (next_state == SHOW) begin
            o_AN       <= next_an;
            o_HALFBYTE <= next_nibble;
            o_DP       <= next_dp_bit;
            o_BLANK    <= next_blank;
        end else begin
            o_AN       <= AN_OFF;
            o_DP       <= 1'b0;
            o_BLANK    <= 1'b1;
        end
    end

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Time-multiplexed scanner for a common-anode multi-digit 7-segment display. It latches a packed hex value and cycles through its digits one at a time. For the active digit it presents one nibble to the downstream hex-to-segment converter, drives the digit anodes, and supplies decimal-point and blanking controls. It sits between the core's debug or value-display bus and the segment converter, and owns all display timing.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned (≥2).
- PRESCALE, 50000, clock cycles each digit is lit (≥1).
- GUARD, 500, clock cycles with all anodes off between digits, to prevent ghosting (≥1).
- AN_ACTIVE_LOW, 1, anode polarity; 1 means a driven digit is 0.

Ports:
- i_CLK  in  1  system clock; single clock domain.
- i_RST  in  1  reset; asynchronous, active-high.
- i_VALUE  in  4*DIGITS  packed value; nibble k (bits 4k+3:4k) maps to digit k, where digit 0 is the rightmost.
- i_LOAD  in  1  single-cycle strobe; captures i_VALUE and i_DP.
- i_DP  in  DIGITS  decimal-point enables, one bit per digit.
- i_LZB  in  1  leading-zero blanking enable; sampled live.
- o_HALFBYTE  out  4  nibble for the current digit, fed to the converter.
- o_AN  out  DIGITS  digit anodes; one-hot in the active polarity, or all inactive.
- o_DP  out  1  decimal point for the current digit (1 = lit).
- o_BLANK  out  1  1 forces all segments off downstream.

## Operation
- **Registers:**
  - shadow (value plus DP), written on i_LOAD.
  - active (value plus DP), used for display.
  - digit index, 0..DIGITS-1.
  - cycle counter, width $clog2(max(PRESCALE,GUARD)).
  - state.
- **State machine:**
  - SHOW: the anode for the current digit is driven. Stays for PRESCALE cycles.
  - GAP: all anodes are inactive and o_BLANK=1. Stays for GUARD cycles. On exit, the digit index increments modulo DIGITS, and the state returns to SHOW.
  - The counter resets to 0 on every state change.
- **Tear-free update:** active loads from shadow only at the GAP→SHOW transition where the index wraps from DIGITS-1 to 0.
- **i_LOAD coinciding with the wrap edge:** i_VALUE/i_DP go into both shadow and active on that edge.
- **Repeated i_LOAD within a frame:** the last one wins.
- **Leading-zero blanking:** digit k>0 is blanked (o_BLANK=1, o_DP still follows the DP bit) when i_LZB=1 and active nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked by this rule, so a value of 0 shows a single "0".
- **Outputs in SHOW:**
  - o_HALFBYTE = active nibble[index].
  - o_DP = active DP[index].
  - o_BLANK = the leading-zero blanking result.
- **Outputs in GAP:**
  - o_HALFBYTE holds its last value.
  - o_DP = 0.
  - o_BLANK = 1.

## Timing
- All outputs are registered and change only on the rising edge of i_CLK.
- **Reset values (asynchronous):**
  - state=SHOW, index=0, counter=0.
  - shadow and active = 0.
  - o_AN = all inactive (all 1s when AN_ACTIVE_LOW=1).
  - o_HALFBYTE=0, o_DP=0, o_BLANK=1.
- **First cycle after reset release:** the first rising edge drives digit 0's anode, with o_HALFBYTE=0 and o_BLANK=0.
- **Periods:**
  - Digit period = PRESCALE + GUARD cycles.
  - Frame = DIGITS × (PRESCALE + GUARD) cycles.
  - Each digit's anode is active for exactly PRESCALE consecutive cycles.
- **Load latency:** a load becomes visible at the start of the next frame, which is at most one frame plus one cycle after i_LOAD.
- **Reset mid-frame:** all state and outputs return immediately to their reset values, and the shadow contents are discarded.

## Structure
- **Shared package, display_pkg**, contains:
  - the scan state enum {SHOW, GAP};
  - a function that maps a one-hot digit select to o_AN using AN_ACTIVE_LOW;
  - localparam helpers for the counter width.
- **Sub-module, scan_prescaler:** a down-counter with a load value and a single-cycle done pulse, reused for both the SHOW and GAP phases.
- The top level holds the FSM, the shadow/active registers, the leading-zero blanking logic and the output registers.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, GUARD=1 and AN_ACTIVE_LOW=1.
- **Reset:** hold i_RST high, then release → o_AN=1111 and o_BLANK=1 during reset; the first edge after release gives o_AN=1110, o_HALFBYTE=0; the anode sequence is 1110,1111,1101,1111,1011,1111,0111,1111 repeating, with 5 cycles per digit.
- **Basic display:** load i_VALUE=16'hA3F0, i_DP=4'b0100 → in the next frame, digits 0..3 show o_HALFBYTE 0,F,3,A; o_DP=1 only while o_AN=1011.
- **Tear-free update:** load 16'h1234 during digit 2 of a frame → digits 2 and 3 still show the old value in that frame; the new value appears from the following digit-0 SHOW.
- **Load on the wrap edge:** pulse i_LOAD on the GAP→SHOW edge into digit 0 with 16'h00C5 → the first SHOW of digit 0 already outputs 5.
- **Leading-zero blanking:** i_VALUE=16'h0070 with i_LZB=1 → digits 3 and 2 have o_BLANK=1, digit 1 shows 7 with o_BLANK=0, and digit 0 shows 0 unblanked; i_VALUE=0 blanks digits 3..1 only.
- **Reset mid-frame:** assert i_RST during digit 2 SHOW → same cycle: o_AN=1111, o_BLANK=1; after release, scanning restarts at digit 0 with a value of 0.
